// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   Passive checker for the red/yellow/green lamps of a traffic-light
//   controller. The lamps are registered, and the phase order
//   red -> green -> yellow -> red is tracked. The monitor measures how many
//   clocks each phase lasts. It raises a sticky fault on an illegal lamp
//   pattern, a wrong phase order, or a phase that is too short or too long.
//   It also counts completed cycles.
//
// Ports
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   red          in   1      red lamp from controller
//   yellow       in   1      yellow lamp from controller
//   green        in   1      green lamp from controller
//   clear_fault  in   1      sync pulse: clear fault and resynchronise
//   phase        out  2      0 sync/fault, 1 red, 2 green, 3 yellow
//   dwell        out  CNT_W  clocks spent in current phase (1 on entry)
//   fault        out  1      sticky fault flag
//   fault_code   out  3      0 none, 1 illegal lamp, 2 bad order,
//                            3 too short, 4 too long
//   cycle_done   out  1      one-clock pulse on each counted red->green
//   cycle_count  out  16     completed cycles, wraps
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_SYNC   | waiting for a one-hot lamp pattern to lock onto
// S_RED    | red phase, dwell counting
// S_GREEN  | green phase, dwell counting
// S_YELLOW | yellow phase, dwell counting
// S_FAULT  | fault latched, lamps ignored until clear_fault or reset
module traffic_light_monitor #(
  parameter int CNT_W     = 8,
  parameter int RED_MIN   = 3,
  parameter int RED_MAX   = 12,
  parameter int GREEN_MIN = 3,
  parameter int GREEN_MAX = 12,
  parameter int YEL_MIN   = 1,
  parameter int YEL_MAX   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             clear_fault,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             cycle_done,
  output logic [15:0]      cycle_count
);

  typedef enum logic [2:0] {S_SYNC, S_RED, S_GREEN, S_YELLOW, S_FAULT} state_t;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  state_t           state_q, state_d;
  logic [2:0]       lamp_q;
  logic [CNT_W-1:0] dwell_d, dwell_inc, cur_min, cur_max;
  logic [2:0]       code_d, cur_lamp, succ_lamp;
  logic             done_d, first_q, first_d, one_hot;
  logic [15:0]      count_d;
  state_t           succ_state, sync_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SYNC;
      lamp_q      <= 3'b000;
      dwell       <= '0;
      fault_code  <= 3'd0;
      cycle_done  <= 1'b0;
      cycle_count <= 16'd0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lamp_q      <= {red, yellow, green};
      dwell       <= dwell_d;
      fault_code  <= code_d;
      cycle_done  <= done_d;
      cycle_count <= count_d;
      first_q     <= first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell;
    code_d     = fault_code;
    done_d     = 1'b0;
    count_d    = cycle_count;
    first_d    = first_q;
    cur_lamp   = 3'b000;
    succ_lamp  = 3'b000;
    succ_state = S_SYNC;
    cur_min    = '0;
    cur_max    = '0;
    sync_state = S_SYNC;
    one_hot    = (lamp_q == L_RED) || (lamp_q == L_YEL) || (lamp_q == L_GRN);
    dwell_inc  = (&dwell) ? dwell : dwell + CNT_W'(1);

    case (state_q)
      S_RED: begin
        cur_lamp = L_RED; succ_lamp = L_GRN; succ_state = S_GREEN;
        cur_min = CNT_W'(RED_MIN); cur_max = CNT_W'(RED_MAX);
      end
      S_GREEN: begin
        cur_lamp = L_GRN; succ_lamp = L_YEL; succ_state = S_YELLOW;
        cur_min = CNT_W'(GREEN_MIN); cur_max = CNT_W'(GREEN_MAX);
      end
      S_YELLOW: begin
        cur_lamp = L_YEL; succ_lamp = L_RED; succ_state = S_RED;
        cur_min = CNT_W'(YEL_MIN); cur_max = CNT_W'(YEL_MAX);
      end
      default: ;
    endcase

    case (lamp_q)
      L_RED:   sync_state = S_RED;
      L_GRN:   sync_state = S_GREEN;
      L_YEL:   sync_state = S_YELLOW;
      default: sync_state = S_SYNC;
    endcase

    if (clear_fault) begin
      state_d = S_SYNC;
      dwell_d = '0;
      code_d  = 3'd0;
      first_d = 1'b0;
    end else begin
      case (state_q)
        // All-dark is what the lamp register holds straight out of reset,
        // so sync waits on it; several lit lamps are still illegal here.
        S_SYNC: begin
          if (one_hot) begin
            state_d = sync_state;
            dwell_d = CNT_W'(1);
            first_d = 1'b1;
          end else if (lamp_q != 3'b000) begin
            state_d = S_FAULT;
            code_d  = 3'd1;
          end
        end
        S_FAULT: ;
        default: begin
          if (!one_hot) begin
            state_d = S_FAULT;
            code_d  = 3'd1;
          end else if (lamp_q == cur_lamp) begin
            // dwell is allowed to show MAX+1 as the value that tripped the fault
            dwell_d = dwell_inc;
            if (dwell >= cur_max) begin
              state_d = S_FAULT;
              code_d  = 3'd4;
            end
          end else if (lamp_q == succ_lamp) begin
            if (!first_q && (dwell < cur_min)) begin
              state_d = S_FAULT;
              code_d  = 3'd3;
            end else begin
              state_d = succ_state;
              dwell_d = CNT_W'(1);
              first_d = 1'b0;
              // a red phase entered mid-way from sync is not a whole cycle
              if ((state_q == S_RED) && !first_q) begin
                done_d  = 1'b1;
                count_d = cycle_count + 16'd1;
              end
            end
          end else begin
            state_d = S_FAULT;
            code_d  = 3'd2;
          end
        end
      endcase
    end
  end

  always_comb begin
    phase = 2'd0;
    case (state_q)
      S_RED:    phase = 2'd1;
      S_GREEN:  phase = 2'd2;
      S_YELLOW: phase = 2'd3;
      default:  phase = 2'd0;
    endcase
    fault = (state_q == S_FAULT);
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        red = 1'b0, yellow = 1'b0, green = 1'b0, clear_fault = 1'b0;
  logic [1:0]  phase;
  logic [7:0]  dwell;
  logic        fault;
  logic [2:0]  fault_code;
  logic        cycle_done;
  logic [15:0] cycle_count;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  traffic_light_monitor dut (
    .clk(clk), .rst_n(rst_n), .red(red), .yellow(yellow), .green(green),
    .clear_fault(clear_fault), .phase(phase), .dwell(dwell), .fault(fault),
    .fault_code(fault_code), .cycle_done(cycle_done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phases numbered 1=red 2=green 3=yellow, so the legal
  // successor of p is p%3+1; limits live in small tables.
  int mn[4] = '{0, 3, 3, 1};
  int mx[4] = '{0, 12, 12, 4};
  logic [2:0] m_lamp = 3'b000;
  int m_phase = 0, m_dwell = 0, m_code = 0, m_count = 0;
  bit m_fault = 0, m_first = 0, m_done = 0;

  function automatic int lamp_phase(input logic [2:0] l);
    case (l)
      3'b100:  return 1;
      3'b001:  return 2;
      3'b010:  return 3;
      default: return 0;
    endcase
  endfunction

  task automatic raise(input int c);
    m_fault = 1; m_code = c; m_phase = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lamp = 3'b000; m_phase = 0; m_dwell = 0; m_code = 0; m_count = 0;
      m_fault = 0; m_first = 0; m_done = 0;
    end else begin
      automatic int lp = lamp_phase(m_lamp);
      m_done = 0;
      if (clear_fault) begin
        m_fault = 0; m_code = 0; m_dwell = 0; m_phase = 0; m_first = 0;
      end else if (!m_fault) begin
        if (m_phase == 0) begin
          if (lp != 0) begin m_phase = lp; m_dwell = 1; m_first = 1; end
          else if (m_lamp != 3'b000) raise(1);
        end else if (lp == 0) raise(1);
        else if (lp == m_phase) begin
          m_dwell = (m_dwell + 1 > 255) ? 255 : m_dwell + 1;
          if (m_dwell > mx[m_phase]) raise(4);
        end else if (lp == m_phase % 3 + 1) begin
          if (!m_first && m_dwell < mn[m_phase]) raise(3);
          else begin
            if (m_phase == 1 && !m_first) begin
              m_done = 1; m_count = (m_count + 1) % 65536;
            end
            m_phase = lp; m_dwell = 1; m_first = 0;
          end
        end else raise(2);
      end
      m_lamp = {red, yellow, green};
    end
  end

  int pk[4] = '{0, 0, 0, 0};
  int pulses = 0;

  always @(negedge clk) begin
    chk("phase", int'(phase), m_phase);
    chk("dwell", int'(dwell), m_dwell);
    chk("fault", int'(fault), int'(m_fault));
    chk("fault_code", int'(fault_code), m_code);
    chk("cycle_done", int'(cycle_done), int'(m_done));
    chk("cycle_count", int'(cycle_count), m_count);
    if (int'(dwell) > pk[phase]) pk[phase] = int'(dwell);
    if (cycle_done) pulses++;
  end

  task automatic step(input logic [2:0] l, input logic clr);
    {red, yellow, green} = l;
    clear_fault = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [2:0] l, input int n);
    for (int i = 0; i < n; i++) step(l, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    #12 rst_n = 1'b1;

    // 1: legal cycles
    hold(R, 6); hold(G, 6); hold(Y, 2); hold(R, 6); hold(G, 6);
    chk("t1_fault", int'(fault), 0);
    chk("t1_count", int'(cycle_count), 1);
    chk("t1_pulses", pulses, 1);
    chk("t1_peak_red", pk[1], 6);
    chk("t1_peak_green", pk[2], 6);
    chk("t1_peak_yellow", pk[3], 2);

    // 2: green too long
    hold(G, 7);
    chk("t2_dwell12", int'(dwell), 12);
    chk("t2_nofault", int'(fault), 0);
    step(G, 1'b0);
    chk("t2_fault", int'(fault), 1);
    chk("t2_code", int'(fault_code), 4);
    chk("t2_phase", int'(phase), 0);

    // 3: green -> red is out of order; later lamps ignored
    step(R, 1'b1); hold(R, 5); hold(G, 6); hold(R, 3);
    chk("t3_code", int'(fault_code), 2);
    hold(G, 3); hold(Y, 2); step(3'b111, 1'b0);
    chk("t3_code_held", int'(fault_code), 2);
    chk("t3_phase", int'(phase), 0);

    // 4: two lamps lit mid-green, then clear and resync on red
    step(R, 1'b1); hold(R, 5); hold(G, 3); step(3'b101, 1'b0); hold(G, 2);
    chk("t4_code", int'(fault_code), 1);
    step(R, 1'b1); hold(R, 5);
    chk("t4_phase", int'(phase), 1);
    chk("t4_fault", int'(fault), 0);
    chk("t4_dwell", int'(dwell), 5);
    chk("t4_count", int'(cycle_count), 1);

    // 5: green too short, then clear coinciding with a bad edge
    hold(G, 2); step(Y, 1'b0); step(Y, 1'b0);
    chk("t5_code", int'(fault_code), 3);
    step(R, 1'b1); hold(R, 6); hold(G, 2); step(Y, 1'b0); step(Y, 1'b1);
    chk("t5_clr_fault", int'(fault), 0);
    chk("t5_clr_phase", int'(phase), 0);
    chk("t5_clr_dwell", int'(dwell), 0);
    step(Y, 1'b0);
    chk("t5_yellow", int'(phase), 3);

    // 6: asynchronous reset mid-yellow
    #2 rst_n = 1'b0;
    #1;
    chk("t6_phase", int'(phase), 0);
    chk("t6_dwell", int'(dwell), 0);
    chk("t6_fault", int'(fault), 0);
    chk("t6_code", int'(fault_code), 0);
    chk("t6_done", int'(cycle_done), 0);
    chk("t6_count", int'(cycle_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hold(R, 5);
    chk("t6_red_phase", int'(phase), 1);
    chk("t6_red_dwell", int'(dwell), 4);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
